// File: rtl/decode_stage.sv
// Registered instruction decoder between fetch and execute.
// Handles the syn/halt sequencing, illegal opcodes and branch flush.
module decode_stage #(
    parameter int INSTR_W = 16,
    parameter int REG_W   = 3,
    localparam int IMM_W  = INSTR_W - 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic               flush,
    input  logic               syn_ack,
    input  logic               restart,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               halt,
    output logic               alu_op,
    output logic               reg_wr_en,
    output logic               mem_wr_en,
    output logic               branch,
    output logic               fft_wr_en,
    output logic               set_en,
    output logic               syn,
    output logic               use_imm,
    output logic               set_freq,
    output logic [1:0]         shift_dist,
    output logic [REG_W-1:0]   reg1,
    output logic [REG_W-1:0]   reg2,
    output logic [IMM_W-1:0]   imm,
    output logic               illegal,
    output logic               err_sticky,
    output logic               halted,
    output logic               syn_wait
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SYN_WAIT = 2'd1,
        HALTED   = 2'd2
    } state_t;

    typedef struct packed {
        logic halt;
        logic alu_op;
        logic reg_wr_en;
        logic mem_wr_en;
        logic branch;
        logic fft_wr_en;
        logic set_en;
        logic syn;
        logic use_imm;
        logic set_freq;
        logic illegal;
    } ctrl_t;

    state_t             r_state;
    ctrl_t              r_ctrl;
    logic               r_out_valid;
    logic               r_err;
    logic [1:0]         r_shift;
    logic [REG_W-1:0]   r_reg1;
    logic [REG_W-1:0]   r_reg2;
    logic [IMM_W-1:0]   r_imm;

    ctrl_t              w_ctrl;
    logic [4:0]         w_opcode;
    logic               w_accept;

    assign w_opcode = instr[INSTR_W-1 -: 5];
    assign in_ready = (r_state == RUN) && !flush &&
                      (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_ctrl = '0;
        casez (w_opcode)
            5'b00000: ;
            5'b00001: w_ctrl.halt = 1'b1;
            5'b001??: begin
                w_ctrl.use_imm   = 1'b1;
                w_ctrl.reg_wr_en = 1'b1;
            end
            5'b01000: w_ctrl.fft_wr_en = 1'b1;
            5'b01001: w_ctrl.mem_wr_en = 1'b1;
            5'b01010: begin
                w_ctrl.alu_op    = 1'b1;
                w_ctrl.reg_wr_en = 1'b1;
            end
            5'b01011: w_ctrl.branch   = 1'b1;
            5'b01100: w_ctrl.set_freq = 1'b1;
            5'b01110: w_ctrl.set_en   = 1'b1;
            5'b01111: w_ctrl.syn      = 1'b1;
            default:  w_ctrl.illegal  = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_ctrl      <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_shift     <= '0;
            r_reg1      <= '0;
            r_reg2      <= '0;
            r_imm       <= '0;
        end else begin
            if (flush)
                r_out_valid <= 1'b0;
            else if (w_accept)
                r_out_valid <= 1'b1;
            else if (out_ready)
                r_out_valid <= 1'b0;

            if (w_accept) begin
                r_ctrl  <= w_ctrl;
                r_shift <= w_opcode[1:0];
                r_reg1  <= instr[INSTR_W-6 -: REG_W];
                r_reg2  <= instr[INSTR_W-6-REG_W -: REG_W];
                r_imm   <= instr[IMM_W-1:0];
            end

            // an illegal accept in the same cycle as restart keeps the flag set
            if (w_accept && w_ctrl.illegal)
                r_err <= 1'b1;
            else if (restart)
                r_err <= 1'b0;

            unique case (r_state)
                RUN: begin
                    if (w_accept && w_ctrl.syn)
                        r_state <= SYN_WAIT;
                    else if (w_accept && w_ctrl.halt)
                        r_state <= HALTED;
                end
                SYN_WAIT: begin
                    if (flush || syn_ack)
                        r_state <= RUN;
                end
                HALTED: begin
                    if (restart)
                        r_state <= RUN;
                end
                default: r_state <= RUN;
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign halt       = r_ctrl.halt;
    assign alu_op     = r_ctrl.alu_op;
    assign reg_wr_en  = r_ctrl.reg_wr_en;
    assign mem_wr_en  = r_ctrl.mem_wr_en;
    assign branch     = r_ctrl.branch;
    assign fft_wr_en  = r_ctrl.fft_wr_en;
    assign set_en     = r_ctrl.set_en;
    assign syn        = r_ctrl.syn;
    assign use_imm    = r_ctrl.use_imm;
    assign set_freq   = r_ctrl.set_freq;
    assign illegal    = r_ctrl.illegal;
    assign shift_dist = r_shift;
    assign reg1       = r_reg1;
    assign reg2       = r_reg2;
    assign imm        = r_imm;
    assign err_sticky = r_err;
    assign halted     = (r_state == HALTED);
    assign syn_wait   = (r_state == SYN_WAIT);

endmodule
